// File: rtl/alu_exec_if.sv
// Valid/ready bundle between operand select, the execute ALU and memory/writeback.
interface alu_exec_if #(
   parameter int XLEN = 32
);
   logic            valid_i;
   logic            ready_o;
   logic [4:0]      aluc_i;
   logic [XLEN-1:0] op_a_i;
   logic [XLEN-1:0] op_b_i;
   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] result_o;
   logic            branch_o;
   logic            illegal_o;

   modport master (
      output valid_i, aluc_i, op_a_i, op_b_i, ready_i,
      input  ready_o, valid_o, result_o, branch_o, illegal_o
   );

   modport slave (
      input  valid_i, aluc_i, op_a_i, op_b_i, ready_i,
      output ready_o, valid_o, result_o, branch_o, illegal_o
   );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: one-cycle ops, iterative shifts, registered result.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter instead.
module alu_exec #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input logic       clk_i,
   input logic       rst_ni,
   alu_exec_if.slave bus
);
   localparam int SW = $clog2(XLEN);

`ifdef ALU_FAST_SHIFT_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DONE = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
`endif

   state_t state_q, state_d;

   logic [XLEN-1:0] a, b;
   logic [SW-1:0]   shamt;
   logic            accept;

   logic [XLEN-1:0] res_c;
   logic            br_c, ill_c;

   logic [XLEN-1:0] res_q;
   logic            br_q, ill_q;

   assign a      = bus.op_a_i;
   assign b      = bus.op_b_i;
   assign shamt  = b[SW-1:0];
   assign accept = bus.valid_i && (state_q == IDLE);

`ifndef ALU_FAST_SHIFT_EN
   logic shreq;
`endif

   always_comb begin
      res_c = '0;
      br_c  = 1'b0;
      ill_c = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      shreq = 1'b0;
`endif
      unique case (bus.aluc_i)
         5'b00000: res_c = a + b;
         5'b01000: res_c = a - b;
         5'b00010: res_c[0] = $signed(a) < $signed(b);
         5'b00011: res_c[0] = a < b;
         5'b00100: res_c = a ^ b;
         5'b00110: res_c = a | b;
         5'b00111: res_c = a & b;
`ifdef ALU_FAST_SHIFT_EN
         5'b00001: res_c = a << shamt;
         5'b00101: res_c = a >> shamt;
         5'b01101: res_c = XLEN'($signed(a) >>> shamt);
`else
         // shamt=0 finishes at once with A; otherwise the shifter takes over
         5'b00001, 5'b00101, 5'b01101: begin
            res_c = a;
            shreq = |shamt;
         end
`endif
         5'b10000: br_c = (a == b);
         5'b10001: br_c = (a != b);
         5'b10100: br_c = $signed(a) < $signed(b);
         5'b10101: br_c = $signed(a) >= $signed(b);
         5'b10110: br_c = a < b;
         5'b10111: br_c = a >= b;
         5'b11111: begin
            res_c = a;
            br_c  = 1'b1;
         end
         default: ill_c = 1'b1;
      endcase
   end

`ifndef ALU_FAST_SHIFT_EN
   logic [XLEN-1:0] sh_q, sh_nx;
   logic [SW-1:0]   cnt_q, cnt_nx, step;
   logic            left_q, fill_q, last;

   always_comb begin
      step   = (cnt_q < SW'(SHIFT_STEP)) ? cnt_q : SW'(SHIFT_STEP);
      cnt_nx = cnt_q - step;
      last   = (cnt_nx == '0);
      if (left_q) sh_nx = sh_q << step;
      else        sh_nx = XLEN'({{XLEN{fill_q}}, sh_q} >> step);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         left_q <= 1'b0;
         fill_q <= 1'b0;
      end else if (accept) begin
         sh_q   <= a;
         cnt_q  <= shamt;
         left_q <= (bus.aluc_i == 5'b00001);
         fill_q <= (bus.aluc_i == 5'b01101) && a[XLEN-1];
      end else if (state_q == SHIFT) begin
         sh_q  <= sh_nx;
         cnt_q <= cnt_nx;
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         res_q <= '0;
         br_q  <= 1'b0;
         ill_q <= 1'b0;
      end else if (accept) begin
         res_q <= res_c;
         br_q  <= br_c;
         ill_q <= ill_c;
      end
`ifndef ALU_FAST_SHIFT_EN
      else if (state_q == SHIFT && last) begin
         res_q <= sh_nx;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      bus.ready_o = 1'b0;
      bus.valid_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.ready_o = 1'b1;
            if (bus.valid_i) begin
`ifdef ALU_FAST_SHIFT_EN
               state_d = DONE;
`else
               state_d = shreq ? SHIFT : DONE;
`endif
            end
         end
`ifndef ALU_FAST_SHIFT_EN
         SHIFT: if (last) state_d = DONE;
`endif
         DONE: begin
            bus.valid_o = 1'b1;
            if (bus.ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.result_o  = res_q;
   assign bus.branch_o  = br_q;
   assign bus.illegal_o = ill_q;
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
Execute-stage ALU that consumes the 5-bit ALU control code from the ALU control decoder, together with two XLEN operands from operand select.
- Produces a registered result, branch-taken flag and illegal-code flag for the memory/writeback stage.
- Valid/ready handshake on both sides.
- Non-shift ops take one cycle. Shifts are iterative, SHIFT_STEP bits per cycle, unless the fast-shift option is compiled in.

Parameters:
XLEN, 32, operand/result width; power of 2, ≥ 8.
SHIFT_STEP, 1, max shift distance per SHIFT cycle; power of 2, ≤ XLEN/2.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  reset; asynchronous assert, active-low.
valid_i  in  1  upstream op valid.
ready_o  out  1  block can accept an op.
aluc_i  in  5  ALU control code.
op_a_i  in  XLEN  operand A (rs1 or PC+4 for jumps).
op_b_i  in  XLEN  operand B (rs2 or immediate).
valid_o  out  1  result valid.
ready_i  in  1  downstream accepts result.
result_o  out  XLEN  registered result.
branch_o  out  1  branch taken / jump.
illegal_o  out  1  aluc_i was not a defined code.

Behaviour:
- Reset values: valid_o=0, result_o=0, branch_o=0, illegal_o=0, state=IDLE; ready_o=1 immediately after reset.
- FSM states: IDLE, SHIFT, DONE. ready_o=1 only in IDLE.
- Accept occurs when valid_i && ready_o. At accept, aluc_i and operands are captured; later input changes have no effect.
- Code map. A, B are operands; shamt = B[log2(XLEN)-1:0]; every other result bit is 0.
  - 00000 ADD: A+B, wraps mod 2^XLEN.
  - 01000 SUB: A-B, wraps.
  - 00001 SLL.
  - 00010 SLT: signed.
  - 00011 SLTU: unsigned.
  - 00100 XOR.
  - 00110 OR.
  - 00111 AND.
  - 00101 SRL.
  - 01101 SRA.
  - 10000 BEQ, 10001 BNE, 10100 BLT (signed), 10101 BGE (signed), 10110 BLTU, 10111 BGEU: result_o=0; branch_o = comparison outcome.
  - 11111 JAL/JALR: result_o=A; branch_o=1.
  - Any other code: result_o=0, branch_o=0, illegal_o=1.
- branch_o=0 for all non-branch, non-jump codes. illegal_o=0 for all defined codes.
- Non-shift op: IDLE→DONE. Outputs register on the accept edge, so valid_o is high the cycle after accept.
- Shift with shamt=0: same as non-shift; result=A.
- Shift with shamt>0: IDLE→SHIFT. A is loaded into a shift register and shamt into a counter.
  - Each SHIFT cycle shifts by min(count, SHIFT_STEP) and decrements count by the same amount.
  - SRA fills with the original A[XLEN-1].
  - When count reaches 0, result registers and state goes DONE.
  - valid_o rises exactly ceil(shamt/SHIFT_STEP)+1 cycles after accept.
- DONE: valid_o=1; result_o, branch_o and illegal_o are held stable while ready_i=0.
  - On valid_o && ready_i: state goes IDLE, valid_o=0 next cycle. Outputs keep their last value but are don't-care.
  - Throughput: at most one op per 2 cycles.
- valid_i while not in IDLE is ignored; upstream must hold it.
- Reset asserted mid-SHIFT or in DONE: immediate return to reset values; the in-flight op is discarded.

Optional Feature:
ALU_FAST_SHIFT_EN
- Defined: shifts use a single-cycle barrel shifter; SHIFT state and counter are not built; every op reaches DONE the cycle after accept; SHIFT_STEP is ignored.
- Undefined: iterative shifting as specified above.

Test Plan:
- Latency/ADD: ADD A=5, B=7 accepted at cycle 0 → cycle 1: valid_o=1, result_o=12, branch_o=0.
- Wrap/SUB: SUB A=3, B=5 → result_o=0xFFFFFFFE. ADD 0xFFFFFFFF+1 → 0.
- Iterative SRA (SHIFT_STEP=1): SRA A=0x80000000, B=4, accepted at cycle 0 → ready_o=0 for cycles 1-5; valid_o=1 at cycle 5; result_o=0xF8000000. SHIFT_STEP=4, shamt=31 → valid_o at cycle 9.
- Branches: BLTU A=1, B=0xFFFFFFFF → branch_o=1. BLT same operands → branch_o=0. JAL A=0x104 → result_o=0x104, branch_o=1.
- Backpressure and illegal code: code 01001 with ready_i=0 for 3 cycles → valid_o=1, illegal_o=1, result_o=0 held stable and ready_o=0 throughout; ready_i=1 → IDLE next cycle.
- Reset mid-operation: SLL A=1, B=20 (SHIFT_STEP=1), rst_ni low at cycle 6 → valid_o=0 immediately. After release, ready_o=1; a new ADD 2+2 gives 4.
